// File: rtl/ld_point_add_if.sv
// Request/result bundle for the López-Dahab point adder: one operand pair in,
// one projective result out.
interface ld_point_add_if #(
  parameter int unsigned N = 3
);
  logic         in_valid;
  logic [N-1:0] X0;
  logic [N-1:0] Y0;
  logic [N-1:0] Z0;
  logic [N-1:0] X1;
  logic [N-1:0] Y1;
  logic [N-1:0] Z1;
  logic         out_valid;
  logic [N-1:0] X2;
  logic [N-1:0] Y2;
  logic [N-1:0] Z2;

  modport master (
    output in_valid, X0, Y0, Z0, X1, Y1, Z1,
    input  out_valid, X2, Y2, Z2
  );

  modport slave (
    input  in_valid, X0, Y0, Z0, X1, Y1, Z1,
    output out_valid, X2, Y2, Z2
  );
endinterface

// File: rtl/ld_point_add.sv
// Elliptic-curve point addition over GF(2^N) in López-Dahab coordinates:
// P0 projective plus P1 affine, one registered result per request.
module ld_point_add #(
  parameter int unsigned    N      = 3,
  parameter logic [N:0]     POLY   = 4'b1101,
  parameter logic [N-1:0]   A_COEF = 3'b100,
  parameter logic [N-1:0]   B_COEF = 3'b001
) (
  input  logic            clk,
  input  logic            rst,
  ld_point_add_if.slave   bus
);

  // Carry-less multiply with on-the-fly reduction by POLY.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0] acc;
    logic [N-1:0] sh;
    logic [N:0]   wide;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(N); i++) begin
      if (b[i]) acc = acc ^ sh;
      wide = {sh, 1'b0};
      if (wide[N]) wide = wide ^ POLY;
      sh = wide[N-1:0];
    end
    return acc;
  endfunction

  function automatic logic [N-1:0] gf_sq(input logic [N-1:0] a);
    return gf_mul(a, a);
  endfunction

  logic [N-1:0] z0_sq;
  logic [N-1:0] a_val;
  logic [N-1:0] b_val;
  logic [N-1:0] m_c;
  logic [N-1:0] m_d;
  logic [N-1:0] m_e;
  logic [N-1:0] m_f;
  logic [N-1:0] m_g;
  logic [N-1:0] m_x;
  logic [N-1:0] m_y;
  logic [N-1:0] m_z;
  logic [N-1:0] d_x0_sq;
  logic [N-1:0] d_bz4;
  logic [N-1:0] d_x;
  logic [N-1:0] d_y;
  logic [N-1:0] d_z;
  logic [N-1:0] x_n;
  logic [N-1:0] y_n;
  logic [N-1:0] z_n;
  logic         p0_inf;
  logic         p1_inf;

  // Shared terms, both candidate results, then case selection.
  always_comb begin
    p0_inf = (bus.Z0 == '0);
    p1_inf = (bus.Z1 == '0);

    z0_sq = gf_sq(bus.Z0);
    a_val = gf_mul(bus.Y1, z0_sq) ^ bus.Y0;
    b_val = gf_mul(bus.X1, bus.Z0) ^ bus.X0;

    m_c = gf_mul(bus.Z0, b_val);
    m_d = gf_mul(gf_sq(b_val), m_c ^ gf_mul(A_COEF, z0_sq));
    m_z = gf_sq(m_c);
    m_e = gf_mul(a_val, m_c);
    m_x = gf_sq(a_val) ^ m_d ^ m_e;
    m_f = m_x ^ gf_mul(bus.X1, m_z);
    m_g = gf_mul(bus.X1 ^ bus.Y1, gf_sq(m_z));
    m_y = gf_mul(m_e ^ m_z, m_f) ^ m_g;

    d_x0_sq = gf_sq(bus.X0);
    d_z     = gf_mul(d_x0_sq, z0_sq);
    d_bz4   = gf_mul(B_COEF, gf_sq(z0_sq));
    d_x     = gf_sq(d_x0_sq) ^ d_bz4;
    d_y     = gf_mul(d_bz4, d_z)
            ^ gf_mul(d_x, gf_mul(A_COEF, d_z) ^ gf_sq(bus.Y0) ^ d_bz4);

    x_n = '0;
    y_n = '0;
    z_n = '0;
    if (p0_inf && p1_inf) begin
      x_n = '0;
      y_n = '0;
      z_n = '0;
    end else if (p1_inf) begin
      x_n = bus.X0;
      y_n = bus.Y0;
      z_n = bus.Z0;
    end else if (p0_inf) begin
      x_n = bus.X1;
      y_n = bus.Y1;
      z_n = N'(1);
    end else if ((a_val == '0) && (b_val == '0)) begin
      x_n = d_x;
      y_n = d_y;
      z_n = d_z;
    end else begin
      x_n = m_x;
      y_n = m_y;
      z_n = m_z;
    end

    // A zero Z means the sum is the point at infinity; emit it canonically.
    if (z_n == '0) begin
      x_n = '0;
      y_n = '0;
    end
  end

  logic         out_valid_q;
  logic [N-1:0] x2_q;
  logic [N-1:0] y2_q;
  logic [N-1:0] z2_q;

  // Result register: values held between requests, strobe lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x2_q        <= '0;
      y2_q        <= '0;
      z2_q        <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        x2_q <= x_n;
        y2_q <= y_n;
        z2_q <= z_n;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.X2        = x2_q;
  assign bus.Y2        = y2_q;
  assign bus.Z2        = z2_q;

endmodule

// File: tb/tb_ld_point_add.sv
// Directed bench for ld_point_add over GF(8), x^3+x^2+1, a=alpha^2, b=1.
module tb_ld_point_add;
  localparam int unsigned N = 3;
  localparam int unsigned W = 3 * N + 1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ld_point_add_if #(.N(N)) bus ();

  ld_point_add #(
    .N      (N),
    .POLY   (4'b1101),
    .A_COEF (3'b100),
    .B_COEF (3'b001)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    obs = {bus.out_valid, bus.X2, bus.Y2, bus.Z2};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed v=%b X=%b Y=%b Z=%b expected v=%b X=%b Y=%b Z=%b",
             tag, obs[9], obs[8:6], obs[5:3], obs[2:0],
             exp[9], exp[8:6], exp[5:3], exp[2:0]);
    end
  endtask

  // Present operands at negedge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic r, input logic v,
                      input logic [N-1:0] x0, input logic [N-1:0] y0,
                      input logic [N-1:0] z0, input logic [N-1:0] x1,
                      input logic [N-1:0] y1, input logic [N-1:0] z1);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.X0 = x0; bus.Y0 = y0; bus.Z0 = z0;
    bus.X1 = x1; bus.Y1 = y1; bus.Z1 = z1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.X0 = '0; bus.Y0 = '0; bus.Z0 = '0;
    bus.X1 = '0; bus.Y1 = '0; bus.Z1 = '0;

    step(1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    check("reset", {1'b0, 3'b000, 3'b000, 3'b000});

    step(1'b1, 1'b1, 3'b110, 3'b001, 3'b001, 3'b111, 3'b010, 3'b001);
    check("reset_beats_valid", {1'b0, 3'b000, 3'b000, 3'b000});

    step(1'b0, 1'b1, 3'b110, 3'b001, 3'b001, 3'b111, 3'b010, 3'b001);
    check("p_plus_2p", {1'b1, 3'b011, 3'b000, 3'b001});

    step(1'b0, 1'b1, 3'b110, 3'b001, 3'b001, 3'b111, 3'b101, 3'b001);
    check("p_minus_2p", {1'b1, 3'b110, 3'b111, 3'b001});

    step(1'b0, 1'b1, 3'b110, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    check("p_plus_o", {1'b1, 3'b110, 3'b001, 3'b001});

    step(1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b110, 3'b001, 3'b001);
    check("o_plus_p", {1'b1, 3'b110, 3'b001, 3'b001});

    step(1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b110, 3'b001, 3'b101);
    check("o_plus_p_z1_any", {1'b1, 3'b110, 3'b001, 3'b001});

    step(1'b0, 1'b1, 3'b110, 3'b001, 3'b001, 3'b110, 3'b001, 3'b001);
    check("double_p", {1'b1, 3'b100, 3'b111, 3'b011});

    step(1'b0, 1'b1, 3'b110, 3'b001, 3'b001, 3'b110, 3'b111, 3'b001);
    check("p_minus_p", {1'b1, 3'b000, 3'b000, 3'b000});

    step(1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    check("o_plus_o", {1'b1, 3'b000, 3'b000, 3'b000});

    // Projective 2P (Z0=alpha^5) plus affine P: 3P with Z2=alpha^6.
    step(1'b0, 1'b1, 3'b100, 3'b111, 3'b011, 3'b110, 3'b001, 3'b010);
    check("proj_2p_plus_p", {1'b1, 3'b111, 3'b000, 3'b110});

    step(1'b0, 1'b0, 3'b110, 3'b001, 3'b001, 3'b111, 3'b010, 3'b001);
    check("idle_hold", {1'b0, 3'b111, 3'b000, 3'b110});

    step(1'b0, 1'b1, 3'b110, 3'b001, 3'b001, 3'b110, 3'b001, 3'b001);
    check("stream_0", {1'b1, 3'b100, 3'b111, 3'b011});
    step(1'b0, 1'b1, 3'b110, 3'b001, 3'b001, 3'b111, 3'b010, 3'b001);
    check("stream_1", {1'b1, 3'b011, 3'b000, 3'b001});
    step(1'b0, 1'b1, 3'b110, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    check("stream_2", {1'b1, 3'b110, 3'b001, 3'b001});

    step(1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    check("stream_end", {1'b0, 3'b110, 3'b001, 3'b001});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
